// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - streams an inclusive register-file address range out over valid/ready
module regfile_dump_reader #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, READ, HOLD, FIN} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] eff_first;
    logic              fire;
    logic              kill;

    assign busy = (state != IDLE);
    assign done = (state == FIN);

    always_comb begin
        eff_first = first_addr;
        if (SKIP_ZERO && first_addr == '0)
            eff_first = ADDR_W'(1);
        fire    = out_valid && out_ready;
        kill    = abort && (state != IDLE);
        state_d = state;
        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_d = (eff_first > last_addr) ? FIN : READ;
                READ: state_d = HOLD;
                // compare before increment so a range ending at the top address never wraps
                HOLD: if (fire) state_d = (rf_addr == last_q) ? FIN : READ;
                FIN:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rf_addr   <= '0;
            last_q    <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_d;
            if (kill) begin
                out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            last_q  <= last_addr;
                            rf_addr <= eff_first;
                        end
                    end
                    READ: begin
                        out_data  <= rf_rdata;
                        out_addr  <= rf_addr;
                        out_valid <= 1'b1;
                    end
                    HOLD: begin
                        if (fire) begin
                            out_valid <= 1'b0;
                            if (rf_addr != last_q)
                                rf_addr <= rf_addr + ADDR_W'(1);
                        end
                    end
                    FIN: ;
                endcase
            end
        end
    end

endmodule
